// File: rtl/lcd_cmd_scheduler_if.sv
// Write-side handshake between the PCI IO-write path and the LCD command scheduler.
interface lcd_cmd_scheduler_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, wr_rs, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_rs, wr_data, output wr_ready);
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// HD44780 write sequencer: (RS, data) FIFO feeding a setup/pulse/hold/exec-wait timer.
// Define LCD_INIT_EN to add the power-up wait and the built-in init command sequence.
module lcd_cmd_scheduler #(
  parameter int FIFO_AW     = 4,
  parameter int T_AS        = 2,
  parameter int T_EPW       = 8,
  parameter int T_AH        = 1,
  parameter int T_EXEC      = 1320,
  parameter int T_EXEC_LONG = 54120,
  parameter int T_PWRUP     = 495000
) (
  input  logic               PCI_CLK,
  input  logic               PCI_RST,
  lcd_cmd_scheduler_if.slave wr,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic               LCD_E,
  output logic [7:0]         LCD_DB
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [19:0]      AS_LD   = 20'(T_AS - 1);
  localparam logic [19:0]      EPW_LD  = 20'(T_EPW - 1);
  localparam logic [19:0]      AH_LD   = 20'(T_AH - 1);
  localparam logic [19:0]      EXEC_LD = 20'(T_EXEC - 1);
  localparam logic [19:0]      LONG_LD = 20'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT_EX
`ifdef LCD_INIT_EN
    , INIT_WAIT
`endif
  } state_t;

  logic [8:0]         mem [DEPTH];
  logic [8:0]         head;
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop, avail, init_active, long_cmd;
  state_t             state, state_n;
  logic [19:0]        cnt, cnt_n;
  logic               rs_n;
  logic [7:0]         db_n;

  assign wr.wr_ready = (count != FULL);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign head        = mem[rptr];
  assign fifo_level  = count;
  assign LCD_RW      = 1'b0;
  assign busy        = (count != '0) || (state != IDLE) || init_active;
  assign long_cmd    = !LCD_RS && (LCD_DB == 8'h01 || LCD_DB[7:1] == 7'b0000001);

  always_ff @(posedge PCI_CLK)
    if (push) mem[wptr] <= {wr.wr_rs, wr.wr_data};

  // avail lags the count by a cycle so a freshly pushed entry is never popped on the next edge
  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      avail    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: ;
      endcase
      avail <= (count != '0) && !pop;
      if (wr.wr_valid && !wr.wr_ready) overflow <= 1'b1;
    end
  end

`ifdef LCD_INIT_EN
  logic [2:0] init_idx, idx_n;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h01;
      default:    return 8'h06;
    endcase
  endfunction

  assign init_active = (init_idx != 3'd5);

  always_ff @(posedge PCI_CLK)
    if (PCI_RST) init_idx <= '0;
    else         init_idx <= idx_n;
`else
  assign init_active = 1'b0;
`endif

  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
`ifdef LCD_INIT_EN
      state <= INIT_WAIT;
      cnt   <= 20'(T_PWRUP - 1);
`else
      state <= IDLE;
      cnt   <= '0;
`endif
      LCD_RS <= 1'b0;
      LCD_DB <= '0;
      LCD_E  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      LCD_RS <= rs_n;
      LCD_DB <= db_n;
      LCD_E  <= (state_n == PULSE);
    end
  end

  // Each timed state holds for (load + 1) cycles: it leaves on the cycle the counter reads zero.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 20'd1 : cnt;
    rs_n    = LCD_RS;
    db_n    = LCD_DB;
    pop     = 1'b0;
`ifdef LCD_INIT_EN
    idx_n   = init_idx;
`endif
    case (state)
      IDLE: begin
`ifdef LCD_INIT_EN
        if (init_active) begin
          rs_n    = 1'b0;
          db_n    = init_cmd(init_idx);
          idx_n   = init_idx + 3'd1;
          cnt_n   = AS_LD;
          state_n = SETUP;
        end else
`endif
        if (avail) begin
          pop          = 1'b1;
          {rs_n, db_n} = head;
          cnt_n        = AS_LD;
          state_n      = SETUP;
        end
      end
      SETUP:   if (cnt == '0) begin cnt_n = EPW_LD; state_n = PULSE; end
      PULSE:   if (cnt == '0) begin cnt_n = AH_LD;  state_n = HOLD;  end
      HOLD:    if (cnt == '0) begin
                 cnt_n   = long_cmd ? LONG_LD : EXEC_LD;
                 state_n = WAIT_EX;
               end
      WAIT_EX: if (cnt == '0) state_n = IDLE;
`ifdef LCD_INIT_EN
      INIT_WAIT: if (cnt == '0) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Randomized bench for lcd_cmd_scheduler against an interval-based timing model of the LCD write rules.
module tb_lcd_cmd_scheduler;
  localparam int FIFO_AW = 4, T_AS = 2, T_EPW = 4, T_AH = 1;
  localparam int T_EXEC = 20, T_EXEC_LONG = 100, T_PWRUP = 50;
  localparam int DEPTH = 1 << FIFO_AW;
`ifdef LCD_INIT_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_scheduler_if wr();
  logic overflow, busy, lcd_rs, lcd_rw, lcd_e;
  logic [FIFO_AW:0] level;
  logic [7:0] lcd_db;

  lcd_cmd_scheduler #(
    .FIFO_AW(FIFO_AW), .T_AS(T_AS), .T_EPW(T_EPW), .T_AH(T_AH),
    .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .T_PWRUP(T_PWRUP)
  ) dut (
    .PCI_CLK(clk), .PCI_RST(rst), .wr(wr),
    .overflow(overflow), .fifo_level(level), .busy(busy),
    .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_DB(lcd_db)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Model: every item gets its pop edge, E-rise edge and finish edge from the timing rules.
  typedef struct {
    int push; int pop; int rise; int fin;
    logic rs; logic [7:0] db; bit fifo;
  } item_t;
  item_t items[$];
  int chain_end = 0, init_end = 0, last_e = 0;
  bit ovf_m = 1'b0, armed = 1'b0;
  int rises[$];
  logic e_prev = 1'b0;
  logic [7:0] init_seq [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int exec_of(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_EXEC_LONG;
    return T_EXEC;
  endfunction

  function automatic void add_item(input int push, input logic rs, input logic [7:0] d, input bit fifo);
    item_t it;
    it.push = push;
    it.pop  = (push + 2 > chain_end + 1) ? push + 2 : chain_end + 1;
    it.rise = it.pop + T_AS;
    it.fin  = it.rise + T_EPW + T_AH + exec_of(rs, d);
    it.rs = rs; it.db = d; it.fifo = fifo;
    chain_end = it.fin;
    items.push_back(it);
  endfunction

  function automatic int level_at(input int k);
    int n = 0;
    foreach (items[i]) if (items[i].fifo && items[i].push <= k && k < items[i].pop) n++;
    return n;
  endfunction

  function automatic void model_reset(input int e);
    items.delete();
    chain_end = e;
    init_end  = e;
    ovf_m     = 1'b0;
    if (INIT) begin
      foreach (init_seq[i]) add_item(e + T_PWRUP - 1, 1'b0, init_seq[i], 1'b0);
      init_end = chain_end;
    end
  endfunction

  task automatic check_outputs();
    int  k   = cyc;
    int  lvl = level_at(k);
    bit  e_exp = 1'b0;
    bit  bsy;
    if (lcd_e === 1'b1 && e_prev !== 1'b1) rises.push_back(k);
    e_prev = lcd_e;
    if (!armed) return;
    bsy = (lvl > 0) || (INIT && k < init_end);
    foreach (items[i]) begin
      if (items[i].rise <= k && k < items[i].rise + T_EPW) e_exp = 1'b1;
      if (items[i].pop <= k && k < items[i].fin) begin
        bsy = 1'b1;
        chk("lcd_rs", lcd_rs, items[i].rs);
        chk("lcd_db", lcd_db, items[i].db);
      end
    end
    chk("lcd_e", lcd_e, e_exp);
    chk("lcd_rw", lcd_rw, 0);
    chk("fifo_level", level, lvl);
    chk("wr_ready", wr.wr_ready, lvl != DEPTH);
    chk("busy", busy, bsy);
    chk("overflow", overflow, ovf_m);
  endtask

  // One clock: check state after the previous edge, then drive inputs for the next edge.
  task automatic step(input logic v, input logic rs, input logic [7:0] d, input logic r);
    int e;
    @(negedge clk);
    check_outputs();
    rst = r; wr.wr_valid = v; wr.wr_rs = rs; wr.wr_data = d;
    e = cyc + 1;
    last_e = e;
    if (r) begin
      model_reset(e);
      armed = 1'b1;
    end else if (v) begin
      if (level_at(e - 1) < DEPTH) add_item(e, rs, d, 1'b1);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (cyc < chain_end + 1 && n < max) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_bound", n < max, 1);
  endtask

  logic [7:0] spc_cmd [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  int         spc_exp [4] = '{108, 108, 108, 28};

  initial begin
    int n0, pe, tgt, n;
    logic [7:0] d;
    wr.wr_valid = 1'b0; wr.wr_rs = 1'b0; wr.wr_data = 8'h00;

    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_db", lcd_db, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", wr.wr_ready, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, INIT);
    if (INIT) step(1'b1, 1'b1, 8'h55, 1'b0);
    drain(2000);

    // single data write: E rises T_AS cycles after RS/DB, two edges after the push
    n0 = rises.size();
    step(1'b1, 1'b1, 8'h41, 1'b0);
    pe = last_e;
    drain(500);
    chk("single_rises", rises.size() - n0, 1);
    if (rises.size() > n0) chk("single_latency", rises[n0] - pe, 2 + T_AS);

    // command followed by data: spacing depends on long vs short exec time
    foreach (spc_cmd[j]) begin
      n0 = rises.size();
      step(1'b1, 1'b0, spc_cmd[j], 1'b0);
      step(1'b1, 1'b1, 8'h42, 1'b0);
      drain(1000);
      chk("pair_rises", rises.size() - n0, 2);
      if (rises.size() > n0 + 1) chk("pair_spacing", rises[n0 + 1] - rises[n0], spc_exp[j]);
    end

    // hold wr_valid high well past full: overflow, push-while-pop-while-full
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    chk("full_level", level, DEPTH);
    chk("full_ready", wr.wr_ready, 0);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    drain(6000);
    chk("ovf_sticky", overflow, 1);

    // sparse random traffic biased towards the long-wait commands
    for (int i = 0; i < 400; i++) begin
      n = int'($urandom_range(0, 7));
      d = (n < 4) ? 8'(n) : 8'($urandom);
      step($urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)), d, 1'b0);
    end
    drain(8000);

    // reset in the middle of an E pulse, then normal service
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    tgt = items[items.size() - 1].rise;
    n = 0;
    while (cyc < tgt + 1 && n < 200) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("pulse_reached", lcd_e, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_e", lcd_e, 0);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, INIT);
    chk("midrst_ovf", overflow, 0);
    n0 = rises.size();
    step(1'b1, 1'b1, 8'h66, 1'b0);
    drain(2000);
    chk("post_rst_rises", rises.size() - n0, INIT ? 6 : 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
